// File: rtl/idli_sqi_sram_if.sv
// SQI bus between the core (initiator) and the SRAM responder.
// Names follow the responder's view: i_ = into the SRAM, o_ = out of it.
interface idli_sqi_sram_if;
    logic       i_sqi_cs_n;
    logic [3:0] i_sqi_sio;
    logic [3:0] o_sqi_sio;
    logic       o_sqi_oe;

    modport master (
        output i_sqi_cs_n,
        output i_sqi_sio,
        input  o_sqi_sio,
        input  o_sqi_oe
    );

    modport slave (
        input  i_sqi_cs_n,
        input  i_sqi_sio,
        output o_sqi_sio,
        output o_sqi_oe
    );
endinterface

// File: rtl/idli_sqi_sram.sv
// SQI SRAM responder: nibble-serial READ (0x03) / WRITE (0x02) with 24-bit address,
// sequential auto-increment, backed by a 2^ADDR_W byte array.
module idli_sqi_sram #(
    parameter int ADDR_W    = 8,
    parameter int DUMMY_CYC = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    idli_sqi_sram_if.slave sqi
);
    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] DUMMY_LAST = (DUMMY_CYC > 0) ? 8'(DUMMY_CYC - 1) : 8'd0;

    logic [7:0]        r_mem [0:(1 << ADDR_W) - 1];
    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [3:0]        r_cmd_hi;
    logic              r_is_read;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_held;
    logic              r_half;
    logic              r_oe;
    logic [3:0]        r_sio;

    logic [7:0]        w_cmd;
    logic [ADDR_W+3:0] w_addr_shift;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]        w_rd_byte;
    logic              w_we;

    assign w_cmd        = {r_cmd_hi, sqi.i_sqi_sio};
    assign w_addr_shift = {r_addr, sqi.i_sqi_sio};
    // With no dummy cycles the first byte is fetched using the address being completed.
    assign w_rd_addr    = (r_state == ST_ADDR) ? w_addr_shift[ADDR_W-1:0] : r_addr;
    assign w_rd_byte    = r_mem[w_rd_addr];
    assign w_we         = i_rst_n && !sqi.i_sqi_cs_n && (r_state == ST_WDATA) && r_half;

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[r_addr] <= {r_held, sqi.i_sqi_sio};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_CMD;
            r_cnt     <= 8'd0;
            r_oe      <= 1'b0;
            r_sio     <= 4'd0;
            r_cmd_hi  <= 4'd0;
            r_is_read <= 1'b0;
            r_addr    <= '0;
            r_held    <= 4'd0;
            r_half    <= 1'b0;
        end else if (sqi.i_sqi_cs_n) begin
            r_state <= ST_CMD;
            r_cnt   <= 8'd0;
            r_oe    <= 1'b0;
            r_sio   <= 4'd0;
            r_half  <= 1'b0;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (r_cnt == 8'd0) begin
                        r_cmd_hi <= sqi.i_sqi_sio;
                        r_cnt    <= 8'd1;
                    end else begin
                        r_cnt <= 8'd0;
                        if (w_cmd == 8'h03) begin
                            r_state   <= ST_ADDR;
                            r_is_read <= 1'b1;
                        end else if (w_cmd == 8'h02) begin
                            r_state   <= ST_ADDR;
                            r_is_read <= 1'b0;
                        end else begin
                            r_state <= ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    r_addr <= w_addr_shift[ADDR_W-1:0];
                    if (r_cnt == 8'd5) begin
                        r_cnt <= 8'd0;
                        if (!r_is_read) begin
                            r_state <= ST_WDATA;
                            r_half  <= 1'b0;
                        end else if (DUMMY_CYC == 0) begin
                            r_state <= ST_RDATA;
                            r_oe    <= 1'b1;
                            r_sio   <= w_rd_byte[7:4];
                            r_half  <= 1'b1;
                        end else begin
                            r_state <= ST_DUMMY;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DUMMY: begin
                    if (r_cnt == DUMMY_LAST) begin
                        r_cnt   <= 8'd0;
                        r_state <= ST_RDATA;
                        r_oe    <= 1'b1;
                        r_sio   <= w_rd_byte[7:4];
                        r_half  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RDATA: begin
                    // r_half set: the high nibble is on the bus, low nibble goes next.
                    if (r_half) begin
                        r_sio  <= w_rd_byte[3:0];
                        r_addr <= r_addr + 1'b1;
                        r_half <= 1'b0;
                    end else begin
                        r_sio  <= w_rd_byte[7:4];
                        r_half <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (!r_half) begin
                        r_held <= sqi.i_sqi_sio;
                        r_half <= 1'b1;
                    end else begin
                        r_half <= 1'b0;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                ST_IGNORE: begin
                    r_oe  <= 1'b0;
                    r_sio <= 4'd0;
                end
                default: begin
                    r_state <= ST_CMD;
                end
            endcase
        end
    end

    assign sqi.o_sqi_sio = r_sio;
    assign sqi.o_sqi_oe  = r_oe;
endmodule
